// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared types and constants for the SSD1306 power-up sequencer
// Command table order: entry 0 is the pre-reset display-off, 1-4 charge pump/precharge, 5-13 panel setup.
package oled_pkg;

   typedef enum logic [2:0] {
      PWR_ON,
      WAIT,
      SEND,
      RST_LO,
      RST_HI,
      VBAT_ON,
      DATA,
      DONE
   } state_t;

   localparam int NUM_CMD  = 14;
   localparam int NUM_DATA = 512;

   // last table index of each command group; the sequencer moves on after sending it
   localparam logic [3:0] CMD_LAST_PRE   = 4'd0;
   localparam logic [3:0] CMD_LAST_PUMP  = 4'd4;
   localparam logic [3:0] CMD_LAST_SETUP = 4'd13;

   function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
      logic [7:0] b;
      case (idx)
         4'd0:    b = 8'hAE;
         4'd1:    b = 8'h8D;
         4'd2:    b = 8'h14;
         4'd3:    b = 8'hD9;
         4'd4:    b = 8'hF1;
         4'd5:    b = 8'h81;
         4'd6:    b = 8'h0F;
         4'd7:    b = 8'hA0;
         4'd8:    b = 8'hC0;
         4'd9:    b = 8'hDA;
         4'd10:   b = 8'h00;
         4'd11:   b = 8'h20;
         4'd12:   b = 8'h00;
         4'd13:   b = 8'hAF;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/oled_spi_tx.sv
// rtl/oled_spi_tx.sv - SPI mode-3 byte serializer, MSB first, with an idle-high gap after each byte
// A byte occupies 18 sclk half-periods: 16 for the bits plus one idle-high sclk period.
module oled_spi_tx #(
   parameter int CLK_DIV = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] byte_in,
   input  logic       dc_in,
   output logic       busy,
   output logic       done,
   output logic       sclk,
   output logic       sdin,
   output logic       dc
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [4:0]    half_cnt;
   logic [7:0]    shreg;

   always_ff @(posedge clk) begin
      done <= 1'b0;
      if (rst) begin
         busy     <= 1'b0;
         sclk     <= 1'b1;
         sdin     <= 1'b0;
         dc       <= 1'b0;
         div_cnt  <= '0;
         half_cnt <= '0;
         shreg    <= '0;
      end else if (!busy) begin
         // the start edge is also the first falling edge, so bit 7 and dc launch together
         if (start) begin
            busy     <= 1'b1;
            sclk     <= 1'b0;
            sdin     <= byte_in[7];
            dc       <= dc_in;
            shreg    <= byte_in;
            div_cnt  <= '0;
            half_cnt <= '0;
         end
      end else if (div_cnt != DIV_LAST) begin
         div_cnt <= div_cnt + 1'b1;
      end else begin
         div_cnt  <= '0;
         half_cnt <= half_cnt + 1'b1;
         if (half_cnt == 5'd17) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            half_cnt <= '0;
         end else if (half_cnt == 5'd15) begin
            // park sdin low while sclk stays high; the panel only samples on rising edges
            sdin <= 1'b0;
         end else if (half_cnt < 5'd15) begin
            if (!half_cnt[0]) begin
               sclk <= 1'b1;
            end else begin
               sclk  <= 1'b0;
               sdin  <= shreg[6];
               shreg <= {shreg[6:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: rtl/oled.sv
// rtl/oled.sv - SSD1306 power-up sequencer: supply/reset pins, command table, 512-byte pattern fill
// Every wait is measured edge-to-edge from the action that starts it to the action that ends it.
module oled
   import oled_pkg::*;
#(
   parameter int CLK_DIV   = 8,
   parameter int DLY_1MS   = 100000,
   parameter int DLY_100MS = 10000000
) (
   input  logic clk,
   input  logic rst,
   output logic sclk,
   output logic sdin,
   output logic dc,
   output logic vdd,
   output logic vbat,
   output logic reset
);

   localparam int DMAX = (DLY_100MS > DLY_1MS) ? DLY_100MS : DLY_1MS;
   localparam int CW   = $clog2(DMAX + 1);
   // two edges are spent entering WAIT and leaving it for the return state
   localparam logic [CW-1:0] LOAD_1MS   = CW'(DLY_1MS - 2);
   localparam logic [CW-1:0] LOAD_100MS = CW'(DLY_100MS - 2);

   state_t        state, state_n, ret, ret_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    ptr, ptr_n;
   logic [8:0]    nbyte, nbyte_n;
   logic          vdd_d, vbat_d, reset_d;
   logic          start, tx_dc, busy, done;
   logic [7:0]    tx_byte;

   always_comb begin
      state_n = state;
      ret_n   = ret;
      cnt_n   = cnt;
      ptr_n   = ptr;
      nbyte_n = nbyte;
      vdd_d   = vdd;
      vbat_d  = vbat;
      reset_d = reset;
      start   = 1'b0;
      tx_byte = cmd_byte(ptr);
      tx_dc   = 1'b0;
      case (state)
         PWR_ON: begin
            vdd_d   = 1'b0;
            cnt_n   = LOAD_1MS;
            ret_n   = SEND;
            state_n = WAIT;
         end
         WAIT: begin
            if (cnt == '0) state_n = ret;
            else           cnt_n   = cnt - 1'b1;
         end
         SEND: begin
            if (done) begin
               ptr_n = ptr + 1'b1;
               if (ptr == CMD_LAST_PRE)        state_n = RST_LO;
               else if (ptr == CMD_LAST_PUMP)  state_n = VBAT_ON;
               else if (ptr == CMD_LAST_SETUP) state_n = DATA;
            end else if (!busy) begin
               start = 1'b1;
            end
         end
         RST_LO: begin
            reset_d = 1'b0;
            cnt_n   = LOAD_1MS;
            ret_n   = RST_HI;
            state_n = WAIT;
         end
         RST_HI: begin
            reset_d = 1'b1;
            cnt_n   = LOAD_1MS;
            ret_n   = SEND;
            state_n = WAIT;
         end
         VBAT_ON: begin
            vbat_d  = 1'b0;
            cnt_n   = LOAD_100MS;
            ret_n   = SEND;
            state_n = WAIT;
         end
         DATA: begin
            tx_byte = nbyte[7:0];
            tx_dc   = 1'b1;
            if (done) begin
               if (nbyte == 9'(NUM_DATA - 1)) state_n = DONE;
               else                           nbyte_n = nbyte + 1'b1;
            end else if (!busy) begin
               start = 1'b1;
            end
         end
         DONE:    ;
         default: state_n = PWR_ON;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PWR_ON;
         ret   <= PWR_ON;
         cnt   <= '0;
         ptr   <= '0;
         nbyte <= '0;
         vdd   <= 1'b1;
         vbat  <= 1'b1;
         reset <= 1'b1;
      end else begin
         state <= state_n;
         ret   <= ret_n;
         cnt   <= cnt_n;
         ptr   <= ptr_n;
         nbyte <= nbyte_n;
         vdd   <= vdd_d;
         vbat  <= vbat_d;
         reset <= reset_d;
      end
   end

   oled_spi_tx #(.CLK_DIV(CLK_DIV)) u_spi (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .byte_in (tx_byte),
      .dc_in   (tx_dc),
      .busy    (busy),
      .done    (done),
      .sclk    (sclk),
      .sdin    (sdin),
      .dc      (dc)
   );

endmodule

// File: tb/tb_oled.sv
// tb/tb_oled.sv - directed bench for oled: reset values, pin timing, command stream, data fill, mid-byte reset
module tb_oled;

   localparam int CLK_DIV   = 2;
   localparam int DLY_1MS   = 20;
   localparam int DLY_100MS = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk, sdin, dc, vdd, vbat, reset;

   oled #(.CLK_DIV(CLK_DIV), .DLY_1MS(DLY_1MS), .DLY_100MS(DLY_100MS)) dut (
      .clk   (clk),
      .rst   (rst),
      .sclk  (sclk),
      .sdin  (sdin),
      .dc    (dc),
      .vdd   (vdd),
      .vbat  (vbat),
      .reset (reset)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] exp_cmd [14] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F,
                                8'hA0, 8'hC0, 8'hDA, 8'h00, 8'h20, 8'h00, 8'hAF};

   // bus monitor, sampled on the falling clk edge
   logic [7:0] byte_q [$];
   logic       bdc_q  [$];
   int         start_q [$];
   int         bitcnt = 0, nfall = 0, dc_bad = 0, sdin_bad = 0;
   int         rst_fall = 0, rst_rise = 0, vbat_fall = 0;
   logic [7:0] shreg = 8'h00;
   logic       byte_dc = 1'b0;
   logic       p_sclk = 1'b1, p_sdin = 1'b0, p_dc = 1'b0, p_reset = 1'b1, p_vbat = 1'b1;

   always @(negedge clk) begin
      if (rst) begin
         bitcnt = 0;
      end else begin
         if (p_sclk && !sclk) begin
            nfall++;
            if (bitcnt == 0) start_q.push_back(cyc);
         end
         if (!p_sclk && sclk) begin
            if (bitcnt == 0) byte_dc = dc;
            else if (dc !== byte_dc) dc_bad++;
            shreg = {shreg[6:0], sdin};
            bitcnt++;
            if (bitcnt == 8) begin
               byte_q.push_back(shreg);
               bdc_q.push_back(byte_dc);
               bitcnt = 0;
            end
         end
         if (dc !== p_dc && !(p_sclk && !sclk)) dc_bad++;
         if (sdin !== p_sdin && !(p_sclk && !sclk) && !(p_sclk && sclk)) sdin_bad++;
         if (p_reset && !reset) rst_fall = cyc;
         if (!p_reset && reset) rst_rise = cyc;
         if (p_vbat && !vbat) vbat_fall = cyc;
      end
      p_sclk  = sclk;
      p_sdin  = sdin;
      p_dc    = dc;
      p_reset = reset;
      p_vbat  = vbat;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_pins(input string tag);
      chk({tag, "_sclk"},  sclk,  1'b1);
      chk({tag, "_sdin"},  sdin,  1'b0);
      chk({tag, "_dc"},    dc,    1'b0);
      chk({tag, "_vdd"},   vdd,   1'b1);
      chk({tag, "_vbat"},  vbat,  1'b1);
      chk({tag, "_reset"}, reset, 1'b1);
   endtask

   task automatic clear_mon();
      byte_q.delete();
      bdc_q.delete();
      start_q.delete();
   endtask

   task automatic wait_bytes(input string tag, input int n, input int budget);
      int k = 0;
      while (byte_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, byte_q.size() >= n, 1'b1);
   endtask

   task automatic release_and_check_first(input string tag);
      int t_rel, k;
      rst = 1'b0;
      @(negedge clk);
      t_rel = cyc;
      chk({tag, "_vdd_on"}, vdd, 1'b0);
      k = 0;
      while (start_q.size() == 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_first_fall_seen"}, start_q.size() > 0, 1'b1);
      chk({tag, "_first_fall_delay"}, start_q[0] - t_rel, DLY_1MS);
   endtask

   initial begin
      int nf;
      rst = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk_reset_pins("rst_hold");
      end
      clear_mon();
      release_and_check_first("run1");

      wait_bytes("cmd_count", 14, 3000);
      for (int i = 0; i < 14; i++) begin
         chk($sformatf("cmd%0d_val", i), byte_q[i], exp_cmd[i]);
         chk($sformatf("cmd%0d_dc", i), bdc_q[i], 1'b0);
      end
      chk("rst_after_ae",     rst_fall > start_q[0], 1'b1);
      chk("rst_low_len",      rst_rise - rst_fall, DLY_1MS);
      chk("rst_high_to_sclk", start_q[1] - rst_rise, DLY_1MS);
      chk("vbat_after_f1",    vbat_fall > start_q[4], 1'b1);
      chk("vbat_settle",      (start_q[5] - vbat_fall) >= DLY_100MS, 1'b1);
      chk("byte_gap",         (start_q[2] - start_q[1]) >= 18 * CLK_DIV, 1'b1);

      wait_bytes("all_bytes", 14 + 512, 30000);
      for (int i = 0; i < 512; i++) begin
         chk($sformatf("data%0d_val", i), byte_q[14 + i], i[7:0]);
         chk($sformatf("data%0d_dc", i), bdc_q[14 + i], 1'b1);
      end
      nf = nfall;
      repeat (100) @(negedge clk);
      chk("no_extra_bytes", byte_q.size(), 14 + 512);
      chk("no_extra_falls", nfall, nf);
      chk("done_sclk",  sclk,  1'b1);
      chk("done_dc",    dc,    1'b1);
      chk("done_sdin",  sdin,  1'b0);
      chk("done_vdd",   vdd,   1'b0);
      chk("done_vbat",  vbat,  1'b0);
      chk("done_reset", reset, 1'b1);
      chk("dc_stable",  dc_bad, 0);
      chk("sdin_edges", sdin_bad, 0);

      rst = 1'b1;
      @(negedge clk);
      chk_reset_pins("rst_in_done");
      repeat (2) @(negedge clk);
      clear_mon();
      rst = 1'b0;
      begin
         int k = 0;
         while (!(byte_q.size() >= 114 && bitcnt == 3) && k < 8000) begin
            @(negedge clk);
            k++;
         end
         chk("reach_data100", byte_q.size() == 114 && bitcnt == 3, 1'b1);
      end
      rst = 1'b1;
      @(negedge clk);
      chk_reset_pins("rst_mid_byte");
      repeat (3) @(negedge clk);
      clear_mon();
      release_and_check_first("run3");
      wait_bytes("restart_byte", 1, 200);
      chk("restart_val", byte_q[0], 8'hAE);
      chk("restart_dc",  bdc_q[0], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
